// File: rtl/fetch_pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer_if
// Instruction-memory bus between the fetch PC sequencer and the imem.
// At most one request is in flight, and each accepted request gets exactly
// one response beat.
//
// Signals
//   imem_req_valid  sequencer -> imem  fetch request
//   imem_req_ready  imem -> sequencer  memory accepts the request
//   imem_req_addr   sequencer -> imem  8-byte-aligned beat address
//   imem_rsp_valid  imem -> sequencer  response beat valid
//   imem_rsp_data   imem -> sequencer  [31:0] word at addr, [63:32] word at addr+4
//
// Modports
//   master  the fetch sequencer side
//   slave   the instruction-memory side
// ---------------------------------------------------------------------------
interface fetch_pc_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
// Owns the fetch PC of the dual-issue front end. It picks the next PC from a
// trap, a slot-0 or slot-1 redirect, or a sequential advance. It also runs the
// imem handshake with at most one request in flight, and holds the fetched
// instruction pair for the IF/ID register while StallF is asserted.
//
// Parameters
//   RESET_PC        fetch PC loaded on reset
//   FETCH_B         bytes per imem beat (two 32-bit instructions)
//
// Ports
//   CLK             clock, rising edge
//   reset           asynchronous, active-low reset
//   StallF          hold the fetch output; no new request issued
//   trap_valid      trap/exception redirect, target trap_vec
//   redir0_valid    redirect from the older slot 0, target redir0_pc
//   redir1_valid    redirect from the younger slot 1, target redir1_pc
//   imem            instruction-memory bus (master side)
//   fetch_valid     output registers hold a bundle
//   fetch_pc        PC of fetch_inst0
//   fetch_inst0     first instruction
//   fetch_inst1     second instruction, meaningful only when fetch_v1=1
//   fetch_v1        inst1 valid (the bundle started on an 8-byte boundary)
//   fetch_misalign  pc[1:0]!=0; fetching halts until a redirect
// ---------------------------------------------------------------------------
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          FETCH_B  = 8
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        StallF,
    input  logic                        trap_valid,
    input  logic [31:0]                 trap_vec,
    input  logic                        redir0_valid,
    input  logic [31:0]                 redir0_pc,
    input  logic                        redir1_valid,
    input  logic [31:0]                 redir1_pc,
    fetch_pc_sequencer_if.master        imem,
    output logic                        fetch_valid,
    output logic [31:0]                 fetch_pc,
    output logic [31:0]                 fetch_inst0,
    output logic [31:0]                 fetch_inst1,
    output logic                        fetch_v1,
    output logic                        fetch_misalign
);

    localparam logic [31:0] STEP_PAIR   = 32'(FETCH_B);
    localparam logic [31:0] STEP_SINGLE = 32'(FETCH_B / 2);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        req_valid;
    logic        req_fire;
    logic        redir_any;
    logic [31:0] redir_target;
    logic        in_flight;

    // Redirect arbitration. The trap wins over slot 0, and slot 0 (older)
    // wins over slot 1. A losing redirect in the same cycle is ignored.
    always_comb begin
        redir_any    = trap_valid || redir0_valid || redir1_valid;
        redir_target = redir1_pc;
        if (trap_valid) begin
            redir_target = trap_vec;
        end else if (redir0_valid) begin
            redir_target = redir0_pc;
        end
    end

    assign req_fire = req_valid && imem.imem_req_ready;

    // A response is still owed to us if we are waiting for one that has not
    // arrived this cycle, or if a request is being accepted right now.
    // A response that arrives in the same cycle as a redirect is already
    // consumed (and discarded), so it does not count as outstanding.
    // Counting it would park the FSM in DROP waiting for a beat that never
    // comes.
    assign in_flight = ((state == WAIT || state == DROP) && !imem.imem_rsp_valid)
                       || req_fire;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A redirect overrides the normal sequence. If a
    // response is still owed, the FSM goes through DROP so that the stale
    // beat is swallowed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ:  if (req_fire) state_next = WAIT;
            WAIT: if (imem.imem_rsp_valid) state_next = REQ;
            DROP: if (imem.imem_rsp_valid) state_next = REQ;
            default: state_next = IDLE;
        endcase
        if (redir_any) begin
            state_next = in_flight ? DROP : REQ;
        end
    end

    // Output logic. A request is only raised when the output slot is free,
    // or will be freed this cycle because the consumer is not stalled.
    // No request is raised from a misaligned PC.
    always_comb begin
        req_valid = 1'b0;
        if (state == REQ && !fetch_misalign && (!fetch_valid || !StallF)) begin
            req_valid = 1'b1;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = {pc[31:3], 3'b000};

    // PC and fetch output registers. A redirect takes priority over a
    // response. A response only loads while in WAIT; responses seen in DROP,
    // IDLE or REQ are stale and ignored. When pc[2] is set, only the upper
    // word of the beat belongs to this bundle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            fetch_valid    <= 1'b0;
            fetch_pc       <= RESET_PC;
            fetch_inst0    <= '0;
            fetch_inst1    <= '0;
            fetch_v1       <= 1'b0;
            fetch_misalign <= 1'b0;
        end else begin
            if (redir_any) begin
                pc             <= redir_target;
                fetch_valid    <= 1'b0;
                fetch_misalign <= (redir_target[1:0] != 2'b00);
            end else if (state == WAIT && imem.imem_rsp_valid) begin
                fetch_valid <= 1'b1;
                fetch_pc    <= pc;
                if (!pc[2]) begin
                    fetch_inst0 <= imem.imem_rsp_data[31:0];
                    fetch_inst1 <= imem.imem_rsp_data[63:32];
                    fetch_v1    <= 1'b1;
                    pc          <= pc + STEP_PAIR;
                end else begin
                    fetch_inst0 <= imem.imem_rsp_data[63:32];
                    fetch_inst1 <= '0;
                    fetch_v1    <= 1'b0;
                    pc          <= pc + STEP_SINGLE;
                end
            end else if (!StallF) begin
                fetch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_sequencer
// Directed bench for fetch_pc_sequencer. Stimulus pushes the request
// addresses and fetch bundles it expects into queues. Two monitors pop and
// compare those queues whenever the DUT performs a handshake or presents a
// new bundle. A small memory model answers each accepted request after a
// programmable latency.
// ---------------------------------------------------------------------------
module tb_fetch_pc_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        StallF;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        redir0_valid;
    logic [31:0] redir0_pc;
    logic        redir1_valid;
    logic [31:0] redir1_pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst0;
    logic [31:0] fetch_inst1;
    logic        fetch_v1;
    logic        fetch_misalign;

    fetch_pc_sequencer_if bus ();

    fetch_pc_sequencer dut (
        .CLK            (CLK),
        .reset          (reset),
        .StallF         (StallF),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .redir0_valid   (redir0_valid),
        .redir0_pc      (redir0_pc),
        .redir1_valid   (redir1_valid),
        .redir1_pc      (redir1_pc),
        .imem           (bus),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_inst0    (fetch_inst0),
        .fetch_inst1    (fetch_inst1),
        .fetch_v1       (fetch_v1),
        .fetch_misalign (fetch_misalign)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic        v1;
    } bundle_t;

    bundle_t     expBundles[$];
    logic [31:0] expReqs[$];
    int          checks = 0;
    int          errors = 0;
    int          memLatency = 0;
    int          cyc;
    logic        prevValid = 1'b0;
    logic        prevStall = 1'b0;

    // Contents of instruction memory: a distinct word for every address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of redirect inputs, starting just after a rising edge
    task automatic applyStimulus(input logic t, input logic [31:0] tv,
                                 input logic r0, input logic [31:0] r0p,
                                 input logic r1, input logic [31:0] r1p);
        trap_valid   = t;
        trap_vec     = tv;
        redir0_valid = r0;
        redir0_pc    = r0p;
        redir1_valid = r1;
        redir1_pc    = r1p;
        tick(1);
        trap_valid   = 1'b0;
        redir0_valid = 1'b0;
        redir1_valid = 1'b0;
    endtask

    // Expect a fetch of the instruction at pc: one request for its beat and
    // one bundle. The bundle is inst0 = word at pc, plus the word at pc+4
    // when pc is 8-aligned.
    task automatic pushFetch(input logic [31:0] pc);
        bundle_t b;
        expReqs.push_back({pc[31:3], 3'b000});
        b.pc    = pc;
        b.inst0 = memWord(pc);
        b.inst1 = memWord(pc + 32'd4);
        b.v1    = ~pc[2];
        expBundles.push_back(b);
    endtask

    // Hold ready high until n handshakes happen (bounded); return cycles used
    task automatic grantRequests(input int n, output int cycles);
        int seen = 0;
        cycles = 0;
        bus.imem_req_ready = 1'b1;
        while (seen < n && cycles < 60) begin
            @(negedge CLK);
            cycles++;
            if (bus.imem_req_valid) seen++;
        end
        @(posedge CLK);
        #1;
        bus.imem_req_ready = 1'b0;
        checkOutput("grantCount", 32'(seen), 32'(n));
    endtask

    // Memory model: each accepted request is answered after memLatency extra cycles
    initial begin
        logic        hsNow;
        logic [31:0] hsAddr;
        logic [31:0] pendAddr;
        int          pendCnt;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        pendAddr = '0;
        pendCnt  = 0;
        forever begin
            @(negedge CLK);
            hsNow  = bus.imem_req_valid && bus.imem_req_ready;
            hsAddr = bus.imem_req_addr;
            @(posedge CLK);
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = {memWord(pendAddr + 32'd4), memWord(pendAddr)};
                end
            end
            if (hsNow) begin
                if (memLatency == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = {memWord(hsAddr + 32'd4), memWord(hsAddr)};
                end else begin
                    pendAddr = hsAddr;
                    pendCnt  = memLatency;
                end
            end
        end
    end

    // Request monitor: every handshake must match the next expected address
    always @(negedge CLK) begin
        if (reset && bus.imem_req_valid && bus.imem_req_ready) begin
            if (expReqs.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedReq: got addr %h expected no request", bus.imem_req_addr);
            end else begin
                checkOutput("reqAddr", bus.imem_req_addr, expReqs[0]);
                void'(expReqs.pop_front());
            end
        end
    end

    // Bundle monitor: a bundle is new unless it was held by StallF in the
    // previous cycle
    always @(negedge CLK) begin
        if (!reset) begin
            prevValid <= 1'b0;
            prevStall <= 1'b0;
        end else begin
            if (fetch_valid && !(prevValid && prevStall)) begin
                if (expBundles.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBundle: got pc %h expected no bundle", fetch_pc);
                end else begin
                    checkOutput("bundlePc", fetch_pc, expBundles[0].pc);
                    checkOutput("bundleInst0", fetch_inst0, expBundles[0].inst0);
                    checkOutput("bundleV1", 32'(fetch_v1), 32'(expBundles[0].v1));
                    if (expBundles[0].v1) begin
                        checkOutput("bundleInst1", fetch_inst1, expBundles[0].inst1);
                    end
                    void'(expBundles.pop_front());
                end
            end
            prevValid <= fetch_valid;
            prevStall <= StallF;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b0;
        StallF             = 1'b0;
        trap_valid         = 1'b0;
        trap_vec           = '0;
        redir0_valid       = 1'b0;
        redir0_pc          = '0;
        redir1_valid       = 1'b0;
        redir1_pc          = '0;
        bus.imem_req_ready = 1'b0;

        // Reset state
        tick(3);
        @(negedge CLK);
        checkOutput("rstFetchValid", 32'(fetch_valid), 32'd0);
        checkOutput("rstFetchPc", fetch_pc, 32'h8000_0000);
        checkOutput("rstV1", 32'(fetch_v1), 32'd0);
        checkOutput("rstMisalign", 32'(fetch_misalign), 32'd0);
        checkOutput("rstReqValid", 32'(bus.imem_req_valid), 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        @(negedge CLK);
        checkOutput("idleNoReq", 32'(bus.imem_req_valid), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("firstReqValid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("firstReqAddr", bus.imem_req_addr, 32'h8000_0000);
        @(posedge CLK);
        #1;

        // Sequential fetch, zero-wait memory: a bundle every 2 cycles
        $display("[TB] sequential fetch");
        pushFetch(32'h8000_0000);
        pushFetch(32'h8000_0008);
        pushFetch(32'h8000_0010);
        grantRequests(3, cyc);
        checkOutput("throughputCycles", 32'(cyc), 32'd5);
        tick(2);

        // redir0 while waiting on a slow response: the response is dropped
        $display("[TB] redirect during WAIT");
        memLatency = 2;
        expReqs.push_back(32'h8000_0018);
        grantRequests(1, cyc);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0104, 1'b0, 32'h0);
        @(negedge CLK);
        checkOutput("dropNoBundle", 32'(fetch_valid), 32'd0);
        @(posedge CLK);
        #1;
        memLatency = 0;
        pushFetch(32'h8000_0104);
        pushFetch(32'h8000_0108);
        grantRequests(2, cyc);
        tick(2);

        // All three redirects at once: trap target wins
        $display("[TB] redirect priority");
        applyStimulus(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0400);
        @(negedge CLK);
        checkOutput("prioReqValid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("prioReqAddr", bus.imem_req_addr, 32'h8000_0200);
        @(posedge CLK);
        #1;
        pushFetch(32'h8000_0200);
        grantRequests(1, cyc);
        tick(2);

        // StallF holds the bundle and blocks new requests
        $display("[TB] stall hold");
        pushFetch(32'h8000_0208);
        grantRequests(1, cyc);
        StallF = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("stallValid", 32'(fetch_valid), 32'd1);
            checkOutput("stallPc", fetch_pc, 32'h8000_0208);
            checkOutput("stallInst0", fetch_inst0, memWord(32'h8000_0208));
            checkOutput("stallNoReq", 32'(bus.imem_req_valid), 32'd0);
            @(posedge CLK);
            #1;
        end
        pushFetch(32'h8000_0210);
        StallF = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge CLK);
        checkOutput("releaseReqValid", 32'(bus.imem_req_valid), 32'd1);
        @(posedge CLK);
        #1;
        bus.imem_req_ready = 1'b0;
        tick(2);

        // Misaligned redirect halts fetching until an aligned redirect
        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0002);
        @(negedge CLK);
        checkOutput("misalignSet", 32'(fetch_misalign), 32'd1);
        checkOutput("misalignNoReq", 32'(bus.imem_req_valid), 32'd0);
        @(posedge CLK);
        #1;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("misalignHoldNoReq", 32'(bus.imem_req_valid), 32'd0);
            @(posedge CLK);
            #1;
        end
        bus.imem_req_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        @(negedge CLK);
        checkOutput("misalignClear", 32'(fetch_misalign), 32'd0);
        @(posedge CLK);
        #1;
        pushFetch(32'h8000_0010);
        grantRequests(1, cyc);
        tick(2);

        // Reset mid-WAIT: the late response is ignored and fetch restarts
        $display("[TB] reset during WAIT");
        memLatency = 2;
        expReqs.push_back(32'h8000_0018);
        grantRequests(1, cyc);
        reset = 1'b0;
        @(negedge CLK);
        checkOutput("midRstFetchPc", fetch_pc, 32'h8000_0000);
        checkOutput("midRstValid", 32'(fetch_valid), 32'd0);
        checkOutput("midRstNoReq", 32'(bus.imem_req_valid), 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        tick(3);
        @(negedge CLK);
        checkOutput("staleIgnored", 32'(fetch_valid), 32'd0);
        checkOutput("restartReqValid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("restartReqAddr", bus.imem_req_addr, 32'h8000_0000);
        @(posedge CLK);
        #1;
        memLatency = 0;
        pushFetch(32'h8000_0000);
        grantRequests(1, cyc);
        tick(2);

        // PC wraps modulo 2^32 with no flag
        $display("[TB] pc wrap");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        pushFetch(32'hFFFF_FFF8);
        pushFetch(32'h0000_0000);
        grantRequests(2, cyc);
        tick(2);
        @(negedge CLK);
        checkOutput("wrapNoMisalign", 32'(fetch_misalign), 32'd0);
        checkOutput("reqQueueDrained", 32'(expReqs.size()), 32'd0);
        checkOutput("bundleQueueDrained", 32'(expBundles.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
